// File: rtl/yj_fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e : FSM encoding (IDLE = 0, BURST = 1)
//   BCNT_W      : burst counter width (MAX_BURST <= 15 so it never wraps)
//   clog2       : elaboration-time ceil(log2(n)) for ID widths
package yj_fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int BCNT_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/basic_reg_clk_p.sv
// Posedge register with load enable and asynchronous active-low reset.
//   clk_i, rst_n_i : clock / async reset
//   en_i           : load d_i when high, hold otherwise
//   d_i, q_o       : data in / registered data out (resets to RST_VAL)
module basic_reg_clk_p #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/yj_rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index (must be < NREQ)
//   any_o : at least one request present
//   idx_o : first requesting index at or after ptr_i, searching cyclically
// Built as rotate-by-ptr, fixed-priority (lowest wins), then un-rotate.
module yj_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IDW-1:0]  idx_o
);

  logic [NREQ-1:0] rot;
  int              off;
  int              sum;

  always_comb begin
    rot = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      rot[k] = req_i[j];
    end
    // descending scan so the lowest rotated position wins
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(ptr_i) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    idx_o = IDW'(sum);
    any_o = |req_i;
  end

endmodule

// File: rtl/yj_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NREQ
// requesters in the write clock domain. Each accepted word is registered
// together with its source ID.
//   CLK, RSTn   : write clock / async active-low reset
//   req_valid   : per-requester word available
//   req_data    : flattened data, slice i = [i*DW +: DW]
//   req_ready   : per-requester accept (transfer = valid & ready)
//   fifo_full   : conservative full flag, stalls all transfers
//   fifo_wen    : registered write strobe
//   fifo_wdata  : registered write data
//   fifo_wid    : registered source ID of fifo_wdata
//   grant_id    : granted requester (meaningful while busy)
//   busy        : FSM in BURST
module yj_fifo_wr_arbiter
  import yj_fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int IDW       = (NREQ > 1) ? clog2(NREQ) : 1,
  parameter int MAX_BURST = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wen,
  output logic [DW-1:0]      fifo_wdata,
  output logic [IDW-1:0]     fifo_wid,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  arb_state_e        state_q;
  logic [IDW-1:0]    grant_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [BCNT_W-1:0] burst_cnt_q;

  logic              pick_any;
  logic [IDW-1:0]    pick_idx;
  logic              in_burst;
  logic              vld_g;
  logic [DW-1:0]     data_g;
  logic              xfer;
  logic              last_beat;
  logic [IDW-1:0]    nxt_ptr;
  logic [IDW+DW-1:0] pay_d;
  logic [IDW+DW-1:0] pay_q;

  yj_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign in_burst = (state_q == ST_BURST);

  // Granted-requester mux and ready decode. Indices >= NREQ never match,
  // so non-power-of-2 NREQ needs no extra guard.
  always_comb begin
    vld_g     = 1'b0;
    data_g    = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        vld_g        = req_valid[i];
        data_g       = req_data[i*DW +: DW];
        req_ready[i] = in_burst && !fifo_full;
      end
    end
  end

  assign xfer      = in_burst && !fifo_full && vld_g;
  assign last_beat = (burst_cnt_q == BCNT_W'(MAX_BURST - 1));
  assign nxt_ptr   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= ST_BURST;
          end
        end
        ST_BURST: begin
          // full freezes everything, including a dropped valid
          if (!fifo_full) begin
            if (vld_g) burst_cnt_q <= burst_cnt_q + 1'b1;
            if (!vld_g || last_beat) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= nxt_ptr;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pay_d = {grant_q, data_g};

  basic_reg_clk_p #(.W(1)) u_wen_reg (
    .clk_i   (CLK),
    .rst_n_i (RSTn),
    .en_i    (1'b1),
    .d_i     (xfer),
    .q_o     (fifo_wen)
  );

  // payload holds on non-transfer cycles
  basic_reg_clk_p #(.W(IDW + DW)) u_pay_reg (
    .clk_i   (CLK),
    .rst_n_i (RSTn),
    .en_i    (xfer),
    .d_i     (pay_d),
    .q_o     (pay_q)
  );

  assign fifo_wid   = pay_q[IDW+DW-1:DW];
  assign fifo_wdata = pay_q[DW-1:0];
  assign grant_id   = grant_q;
  assign busy       = in_burst;

endmodule

// File: tb/tb_yj_fifo_wr_arbiter.sv
module tb_yj_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int MAXB = 4;

  logic               CLK;
  logic               RSTn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wen;
  logic [DW-1:0]      fifo_wdata;
  logic [IDW-1:0]     fifo_wid;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  yj_fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .MAX_BURST(MAXB)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .fifo_wid   (fifo_wid),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference model state (plain integers, arbitration by cyclic search)
  bit          m_busy;
  int          m_g, m_cnt, m_ptr;
  bit          e_wen;
  logic [31:0] e_wdata;
  int          e_wid;

  // requester-side stimulus state
  logic [31:0] dat [NREQ];
  int          rem [NREQ];
  logic [31:0] sbq [NREQ][$];
  int          gq[$];
  bit          busy_prev;
  logic [9:0]  wen_hist;
  int          wen_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
    e_wen = 0; e_wdata = '0; e_wid = 0;
    for (int i = 0; i < NREQ; i++) begin
      sbq[i].delete();
      rem[i] = 0;
    end
    busy_prev = 0;
    wen_hist  = '0;
    wen_cnt   = 0;
    gq.delete();
  endtask

  // Called at a negedge: assert reset, check outputs right away, release next negedge.
  task automatic do_reset();
    RSTn = 1'b0;
    model_reset();
    #1;
    chk("rst_wen",   fifo_wen,   0);
    chk("rst_wdata", fifo_wdata, 0);
    chk("rst_wid",   fifo_wid,   0);
    chk("rst_gid",   grant_id,   0);
    chk("rst_busy",  busy,       0);
    chk("rst_ready", req_ready,  0);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // One clock cycle: drive inputs, check everything against the model,
  // advance the model, then move to the next negedge.
  task automatic step(input logic [NREQ-1:0] want, input logic full);
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] er;
    logic [31:0]     w;
    bit              xfer, found;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = want[i] && (rem[i] != 0);
      req_data[i*DW +: DW] = dat[i];
    end
    req_valid = v;
    fifo_full = full;
    #1;
    er = '0;
    if (m_busy && !full) er[m_g] = 1'b1;
    chk("ready", req_ready,  er);
    chk("busy",  busy,       m_busy);
    chk("gid",   grant_id,   m_g);
    chk("wen",   fifo_wen,   e_wen);
    chk("wdata", fifo_wdata, e_wdata);
    chk("wid",   fifo_wid,   e_wid);
    if (fifo_wen) begin
      wen_cnt++;
      chk("sb_avail", 64'(sbq[fifo_wid].size() != 0), 1);
      if (sbq[fifo_wid].size() != 0) begin
        w = sbq[fifo_wid].pop_front();
        chk("sb_data", fifo_wdata, w);
      end
    end
    wen_hist = {wen_hist[8:0], fifo_wen};
    if (busy && !busy_prev) gq.push_back(int'(grant_id));
    busy_prev = busy;

    // model next state
    xfer  = m_busy && v[m_g] && !full;
    e_wen = xfer;
    if (xfer) begin
      e_wdata = dat[m_g];
      e_wid   = m_g;
      sbq[m_g].push_back(dat[m_g]);
      dat[m_g] = dat[m_g] + 1;
      rem[m_g] = rem[m_g] - 1;
    end
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (!found && v[j]) begin
          found = 1; m_g = j; m_cnt = 0; m_busy = 1;
        end
      end
    end else if (!full) begin
      if (!v[m_g]) begin
        m_busy = 0; m_ptr = (m_g + 1) % NREQ;
      end else begin
        m_cnt++;
        if (m_cnt == MAXB) begin
          m_busy = 0; m_ptr = (m_g + 1) % NREQ;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic [NREQ-1:0] want;

  initial begin
    RSTn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) dat[i] = {i[7:0], 24'h000100};
    model_reset();
    @(negedge CLK);

    // single requester: 6 words -> 4, bubble, 2
    do_reset();
    dat[0] = 32'hA0;
    rem[0] = 6;
    for (int c = 0; c < 10; c++) step(4'b0001, 1'b0);
    chk("single_pattern", wen_hist, 10'b0011110110);
    chk("single_words",   wen_cnt,  6);

    // all four valid: grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 1 << 20;
    for (int c = 0; c < 25; c++) step(4'b1111, 1'b0);
    chk("rr_bursts", 64'(gq.size() >= 5), 1);
    if (gq.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_order", gq[k], k % NREQ);

    // full stall in the middle of a req1 burst
    do_reset();
    rem[1] = 4;
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(4'b0010, 1'b1);
      chk("stall_gid",  grant_id, 1);
      chk("stall_busy", busy,     1);
    end
    for (int c = 0; c < 6; c++) step(4'b0010, 1'b0);
    chk("stall_words", wen_cnt, 4);

    // early drop: req3 stops after 2 words while req0 waits
    do_reset();
    rem[2] = 1;
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b0);
    rem[3] = 2;
    rem[0] = 1 << 20;
    gq.delete();
    for (int c = 0; c < 7; c++) step(4'b1001, 1'b0);
    chk("drop_n", 64'(gq.size() >= 2), 1);
    if (gq.size() >= 2) begin
      chk("drop_first", gq[0], 3);
      chk("drop_next",  gq[1], 0);
    end

    // reset mid-burst, then re-grant to requester 2
    do_reset();
    rem[0] = 1 << 20;
    for (int c = 0; c < 3; c++) step(4'b0001, 1'b0);
    req_valid = 4'b0100;
    do_reset();
    rem[2] = 1 << 20;
    for (int c = 0; c < 2; c++) step(4'b0100, 1'b0);
    chk("rst_regrant", grant_id, 2);
    chk("rst_regrant_busy", busy, 1);

    // randomized scoreboard run
    do_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 1 << 30;
    want = '0;
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!want[i])                        want[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 15) == 0) want[i] = 1'b0;
      end
      step(want, $urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 3; c++) step('0, 1'b0);
    for (int i = 0; i < NREQ; i++) chk("sb_drain", sbq[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
